// File: rtl/ghash_block_if.sv
// Block/key/result bundle between the GCM datapath and the GHASH accumulator.
// Vectors are [127:0] with bit 127 = GCM bit 0, so hex literals read in GCM order.
interface ghash_block_if;
  logic         iInit;
  logic [127:0] iHashKey;
  logic         iHashKey_valid;
  logic [127:0] iBlock;
  logic         iBlock_valid;
  logic         oReady;
  logic [127:0] oResult;
  logic         oResult_valid;

  modport master (
    output iInit, iHashKey, iHashKey_valid, iBlock, iBlock_valid,
    input  oReady, oResult, oResult_valid
  );

  modport slave (
    input  iInit, iHashKey, iHashKey_valid, iBlock, iBlock_valid,
    output oReady, oResult, oResult_valid
  );
endinterface

// File: rtl/ghash_block.sv
// GHASH accumulator: Y = (Y ^ X) * H in GF(2^128), digit-serial multiplier
// scanning BITS_PER_CYCLE (1,2,4,8) bits of the accumulated operand per clock.
module ghash_block #(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic         iClk,
  input  logic         iRstn,
  ghash_block_if.slave bus
);
  localparam int unsigned W           = 128;
  localparam int unsigned MULT_CYCLES = W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W       = 7;
  localparam logic [W-1:0] R_POLY     = {8'hE1, 120'h0};

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     y_q, y_d, h_q, h_d, z_q, z_d, v_q, v_d, a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     z_step, v_step;

  // One digit of shift-and-add; the scanned operand is consumed from GCM bit 0 (vector MSB).
  always_comb begin
    z_step = z_q;
    v_step = v_q;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (a_q[W-1-k]) z_step = z_step ^ v_step;
      v_step = v_step[0] ? ((v_step >> 1) ^ R_POLY) : (v_step >> 1);
    end
  end

  assign bus.oReady        = (state_q == IDLE) & ~bus.iInit & ~bus.iHashKey_valid;
  assign bus.oResult       = y_q;
  assign bus.oResult_valid = valid_q;

  // Next-state and datapath updates; init overrides everything except reset.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    h_d     = h_q;
    z_d     = z_q;
    v_d     = v_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (bus.iInit) begin
      y_d     = '0;
      z_d     = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.iHashKey_valid) begin
            h_d = bus.iHashKey;
          end else if (bus.iBlock_valid) begin
            a_d     = y_q ^ bus.iBlock;
            v_d     = h_q;
            z_d     = '0;
            cnt_d   = '0;
            state_d = MULT;
          end
        end
        MULT: begin
          z_d   = z_step;
          v_d   = v_step;
          a_d   = a_q << BITS_PER_CYCLE;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MULT_CYCLES - 1)) state_d = DONE;
        end
        DONE: begin
          y_d     = z_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state_q <= IDLE;
      y_q     <= '0;
      h_q     <= '0;
      z_q     <= '0;
      v_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      h_q     <= h_d;
      z_q     <= z_d;
      v_q     <= v_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end
endmodule
